// File: rtl/uart_apb_arbiter.sv
// Two-requester APB arbiter in front of a single UART controller slave port.
// Round-robin on ties, optional ACCESS-phase timeout that completes with PSLVERR.
module uart_apb_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_PADDR,
    input  logic              m0_PSEL,
    input  logic              m0_PENABLE,
    input  logic              m0_PWRITE,
    input  logic [31:0]       m0_PWDATA,
    output logic              m0_PREADY,
    output logic [31:0]       m0_PRDATA,
    output logic              m0_PSLVERR,

    input  logic [ADDR_W-1:0] m1_PADDR,
    input  logic              m1_PSEL,
    input  logic              m1_PENABLE,
    input  logic              m1_PWRITE,
    input  logic [31:0]       m1_PWDATA,
    output logic              m1_PREADY,
    output logic [31:0]       m1_PRDATA,
    output logic              m1_PSLVERR,

    output logic [ADDR_W-1:0] s_PADDR,
    output logic              s_PSEL,
    output logic              s_PENABLE,
    output logic              s_PWRITE,
    output logic [31:0]       s_PWDATA,
    input  logic              s_PREADY,
    input  logic [31:0]       s_PRDATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic        gnt_vld_q, gnt_vld_d;
    logic        gnt_q, gnt_d;
    logic        rr_q, rr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        s_psel_q, s_penable_q;

    logic [1:0]        m_psel, m_penable, m_pwrite;
    logic [1:0]        m_pready, m_pslverr;
    logic [ADDR_W-1:0] m_paddr  [2];
    logic [31:0]       m_pwdata [2];
    logic [31:0]       m_prdata [2];

    logic winner, done, err, timeout_hit, g_psel, g_penable;

    assign m_psel    = {m1_PSEL, m0_PSEL};
    assign m_penable = {m1_PENABLE, m0_PENABLE};
    assign m_pwrite  = {m1_PWRITE, m0_PWRITE};
    assign m_paddr[0]  = m0_PADDR;
    assign m_paddr[1]  = m1_PADDR;
    assign m_pwdata[0] = m0_PWDATA;
    assign m_pwdata[1] = m1_PWDATA;

    assign g_psel      = m_psel[gnt_q];
    assign g_penable   = m_penable[gnt_q];
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        cnt_d     = 16'd0;
        winner    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|m_psel) begin
                    // rr_q holds the last master granted; a tie goes to the other one
                    winner  = (&m_psel) ? ~rr_q : m_psel[1];
                    gnt_d   = winner;
                    rr_d    = winner;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = g_psel ? ACCESS : IDLE;
            end
            ACCESS: begin
                cnt_d = cnt_q + 16'd1;
                if (!g_psel) begin
                    state_d = IDLE;
                end else if (s_PREADY && g_penable) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit && !s_PREADY) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_vld_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_vld_q   <= 1'b0;
            gnt_q       <= 1'b0;
            rr_q        <= 1'b1;
            cnt_q       <= 16'd0;
            s_psel_q    <= 1'b0;
            s_penable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_vld_q   <= gnt_vld_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            s_psel_q    <= (state_d != IDLE);
            s_penable_q <= (state_d == ACCESS);
        end
    end

    assign s_PSEL    = s_psel_q;
    assign s_PENABLE = s_penable_q;
    assign s_PADDR   = gnt_vld_q ? m_paddr[gnt_q]  : '0;
    assign s_PWRITE  = gnt_vld_q ? m_pwrite[gnt_q] : 1'b0;
    assign s_PWDATA  = gnt_vld_q ? m_pwdata[gnt_q] : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign m_pready[gi]  = done && (gnt_q == 1'(gi));
            assign m_pslverr[gi] = m_pready[gi] && err;
            assign m_prdata[gi]  = (m_pready[gi] && !err) ? s_PRDATA : 32'd0;
        end
    endgenerate

    assign m0_PREADY  = m_pready[0];
    assign m0_PSLVERR = m_pslverr[0];
    assign m0_PRDATA  = m_prdata[0];
    assign m1_PREADY  = m_pready[1];
    assign m1_PSLVERR = m_pslverr[1];
    assign m1_PRDATA  = m_prdata[1];

endmodule

// File: doc/uart_apb_arbiter.md
UART_APB_ARBITER -- requirements
Module: uart_apb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, APB address width for both master ports and the slave port.
REQ-002 Parameter TIMEOUT, default 0, maximum ACCESS-state cycles before a forced error completion; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 mN_PADDR/mN_PSEL/mN_PENABLE/mN_PWRITE/mN_PWDATA  input  ADDR_W/1/1/1/32  APB requester N, N in {0,1}.
REQ-006 mN_PREADY/mN_PRDATA/mN_PSLVERR  output  1/32/1  APB completion signals to requester N.
REQ-007 s_PADDR/s_PSEL/s_PENABLE/s_PWRITE/s_PWDATA  output  ADDR_W/1/1/1/32  APB port to the shared UART controller.
REQ-008 s_PREADY/s_PRDATA  input  1/32  completion from the UART controller.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-010 A request from N SHALL be mN_PSEL=1; PENABLE is not required for a request.
REQ-011 IDLE with at least one request: latch the grant, go to SETUP next cycle.
REQ-012 Two simultaneous requests in IDLE: grant the master not served last (round-robin bit); the winner SHALL update the bit at grant.
REQ-013 SETUP SHALL last one cycle with s_PSEL=1, s_PENABLE=0, then go to ACCESS.
REQ-014 ACCESS SHALL drive s_PSEL=1 and s_PENABLE=1 until s_PREADY=1.
REQ-015 s_PSEL and s_PENABLE SHALL be registered FSM outputs.
REQ-016 s_PADDR, s_PWRITE and s_PWDATA SHALL be combinationally muxed from the granted master; they SHALL be 0 in IDLE.
REQ-017 Completion: in ACCESS with s_PREADY=1 and granted mN_PENABLE=1, mN_PREADY=1 SHALL be asserted combinationally that cycle, with mN_PRDATA=s_PRDATA and mN_PSLVERR=0; next state IDLE.
REQ-018 In every other cycle, mN_PREADY SHALL be 0 and mN_PRDATA SHALL be 0, including for a master waiting in its access phase while not granted.
REQ-019 Latency with the arbiter idle: master PSEL at cycle 0 -> s_PSEL at cycle 1 -> s_PENABLE at cycle 2 -> earliest mN_PREADY at cycle 2.
REQ-020 Back-to-back: after completion, IDLE SHALL last at least one cycle before the next SETUP; s_PSEL SHALL drop for that cycle.
REQ-021 Non-granted requester: its request SHALL be held pending; it SHALL be granted in the IDLE cycle after the current completion.
REQ-022 Abort: if the granted mN_PSEL falls in SETUP or ACCESS, go to IDLE next cycle, assert no PREADY, and leave the round-robin bit as updated at grant.
REQ-023 Timeout (TIMEOUT>0): a 16-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle.
REQ-024 Timeout action: when the counter reaches TIMEOUT-1 with s_PREADY=0, assert mN_PREADY=1 and mN_PSLVERR=1 with mN_PRDATA=0, and go to IDLE.
REQ-025 If s_PREADY=1 arrives in the same cycle as a timeout, normal completion SHALL win (PSLVERR=0).
REQ-026 Slave PREADY seen outside ACCESS SHALL be ignored.
REQ-027 Requests SHALL NOT be queued beyond the live PSEL level; no FIFO.

Reset
REQ-028 Reset SHALL asynchronously force state IDLE, s_PSEL=0, s_PENABLE=0, grant=none, timeout counter=0 and round-robin bit=1, so m0 wins the first tie.
REQ-029 While reset is asserted, all outputs SHALL be 0.
REQ-030 Reset mid-transfer SHALL drop s_PSEL in the same cycle; no PREADY is asserted for the aborted transfer.

Verification
REQ-031 m0 reads addr 0x0 alone, slave PREADY=1 with PRDATA=0x8000_0000 -> s_PSEL at cycle 1, s_PENABLE at cycle 2, m0_PREADY=1 with m0_PRDATA=0x8000_0000 at cycle 2.
REQ-032 m0 and m1 request together after reset -> m0 served first; m1 SETUP follows one IDLE cycle after m0 completion; the next tie goes to m0 again only after m1 is served.
REQ-033 m1 writes 0x0004_019F to addr 0x8 while the slave holds PREADY=0 for 20 cycles -> s_PENABLE held 20 cycles, then m1_PREADY=1 for exactly one cycle, m0 stalled throughout.
REQ-034 TIMEOUT=8, slave never ready -> m0_PREADY=1 and m0_PSLVERR=1 on the 8th ACCESS cycle, then IDLE; with s_PREADY rising on that same cycle -> PSLVERR=0.
REQ-035 Reset asserted during ACCESS -> s_PSEL=0 immediately; after release, a simultaneous m0/m1 request grants m0.
REQ-036 m1 drops PSEL during its SETUP -> arbiter returns to IDLE with no m1_PREADY; a pending m0 is granted next.
